control_pipe: RTL and testbench
===============================

CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width of all rs/rd ports.
REQ-002 Parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-low.
REQ-005 op_i  input  7  opcode of the instruction currently in ID.
REQ-006 noop_i  input  1  forces the ID instruction to decode as a bubble.
REQ-007 flush_i  input  1  when 1, the ID instruction is squashed (branch taken).
REQ-008 rs1_i, rs2_i, rd_i  input  ADDR_W each  source and destination register fields of the ID instruction.
REQ-009 id_branch_o, id_jump_o  output  1 each  combinational branch/jump decode of the ID instruction.
REQ-010 stall_o  output  1  combinational load-use hazard; the PC and IF/ID register hold while it is 1.
REQ-011 ex_aluop_o (2), ex_alusrc_o, ex_memread_o (1), ex_rd_o (ADDR_W)  outputs  ID/EX control register.
REQ-012 mem_memread_o, mem_memwrite_o, mem_memtoreg_o, mem_regwrite_o (1 each), mem_rd_o (ADDR_W)  outputs  EX/MEM control register.
REQ-013 wb_memtoreg_o, wb_regwrite_o (1 each), wb_rd_o (ADDR_W)  outputs  MEM/WB control register.
REQ-014 bubble_cnt_o  output  CNT_W  saturating count of bubbles inserted into ID/EX.

Function
REQ-015 The decode table SHALL give {ALUOp, ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite, Branch, Jump} per op_i as follows:
- R 0110011: {10,0,0,0,0,1,0,0}
- I-ALU 0010011: {11,1,0,0,0,1,0,0}
- load 0000011: {00,1,1,1,0,1,0,0}
- store 0100011: {00,1,0,0,1,0,0,0}
- beq 1100011: {01,0,0,0,0,0,1,0}
- jal 1101111: {00,0,0,0,0,1,0,1}
- any other opcode: all zero.
REQ-016 With noop_i=1, the decode SHALL be all zero regardless of op_i.
REQ-017 rs1 is used by R, I-ALU, load, store and beq; rs2 is used by R, store and beq only.
REQ-018 The ID/EX destination rd SHALL be rd_i for ops with RegWrite=1, else 0.
REQ-019 stall_o SHALL be 1 iff all of the following hold:
- ex_memread_o=1
- ex_rd_o!=0
- ex_rd_o equals a used source (rs1_i or rs2_i per REQ-017)
- noop_i=0
- flush_i=0
REQ-020 id_branch_o and id_jump_o SHALL be the decoded Branch/Jump gated to 0 when stall_o=1 or flush_i=1.
REQ-021 A bubble SHALL be loaded into ID/EX each cycle where noop_i=1, flush_i=1, or stall_o=1: all control bits 0 and rd 0.
REQ-022 Otherwise ID/EX SHALL load the decoded control and rd.
REQ-023 EX/MEM and MEM/WB SHALL advance unconditionally every cycle, giving one cycle per stage and a three-cycle ID-to-WB latency.
REQ-024 EX/MEM SHALL carry the MemRead/MemWrite/MemtoReg/RegWrite/rd fields held in ID/EX; MEM/WB SHALL carry MemtoReg/RegWrite/rd.
REQ-025 A simultaneous flush_i and stall condition SHALL insert exactly one bubble and increment bubble_cnt_o by exactly one.
REQ-026 bubble_cnt_o SHALL increment by 1 per bubble cycle (REQ-021) and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 A stall SHALL last exactly one cycle, since the inserted bubble clears ex_memread_o.

Reset
REQ-028 While rst_i=0, every registered output (all ex_/mem_/wb_ outputs and bubble_cnt_o) SHALL be 0 immediately, independent of clk_i.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight control.
REQ-030 After rst_i deasserts, the first rising edge SHALL load ID/EX per REQ-021/REQ-022.

Verification
REQ-031 Scenario: reset, then op_i=0110011, rd_i=3 for 1 cycle -> ex_aluop_o=10, ex_rd_o=3; two cycles later wb_regwrite_o=1, wb_rd_o=3.
REQ-032 Scenario: load rd=5, then beq rs1=5 -> stall_o=1 and id_branch_o=0 for one cycle; bubble_cnt_o=1; the beq enters EX on the next cycle.
REQ-033 Scenario: load rd=0, then R rs1=0 -> stall_o stays 0.
REQ-034 Scenario: load rd=6, then I-ALU rs1=1 rs2=6 -> no stall (rs2 unused).
REQ-035 Scenario: flush_i=1 during a load-use stall -> one bubble, bubble_cnt_o +1 only.
REQ-036 Scenario: CNT_W=2, five consecutive noop_i cycles -> bubble_cnt_o reads 1,2,3,3,3; rst_i=0 mid-sequence -> all outputs 0 at once.

Source files
------------

// File: rtl/control_pipe.sv
// Control path of a 5-stage in-order pipeline: ID decode, load-use hazard
// detection, and the ID/EX, EX/MEM and MEM/WB control registers.
module control_pipe #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        op_i,
  input  logic              noop_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              id_branch_o,
  output logic              id_jump_o,
  output logic              stall_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_memread_o,
  output logic [ADDR_W-1:0] ex_rd_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic              mem_memtoreg_o,
  output logic              mem_regwrite_o,
  output logic [ADDR_W-1:0] mem_rd_o,
  output logic              wb_memtoreg_o,
  output logic              wb_regwrite_o,
  output logic [ADDR_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic       jump;
  } dec_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
  } ex_ctrl_t;

  dec_t              dec;
  logic              use_rs1;
  logic              use_rs2;
  logic              bubble;
  ex_ctrl_t          ex_d;
  logic [ADDR_W-1:0] ex_rd_d;

  ex_ctrl_t          ex_q;
  logic [ADDR_W-1:0] ex_rd_q;
  logic              mem_memread_q;
  logic              mem_memwrite_q;
  logic              mem_memtoreg_q;
  logic              mem_regwrite_q;
  logic [ADDR_W-1:0] mem_rd_q;
  logic              wb_memtoreg_q;
  logic              wb_regwrite_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  // Opcode decode; source-register usage depends only on the opcode.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op_i)
      OP_R: begin
        dec     = '{aluop: 2'b10, alusrc: 1'b0, memtoreg: 1'b0, memread: 1'b0,
                    memwrite: 1'b0, regwrite: 1'b1, branch: 1'b0, jump: 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec     = '{aluop: 2'b11, alusrc: 1'b1, memtoreg: 1'b0, memread: 1'b0,
                    memwrite: 1'b0, regwrite: 1'b1, branch: 1'b0, jump: 1'b0};
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        dec     = '{aluop: 2'b00, alusrc: 1'b1, memtoreg: 1'b1, memread: 1'b1,
                    memwrite: 1'b0, regwrite: 1'b1, branch: 1'b0, jump: 1'b0};
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec     = '{aluop: 2'b00, alusrc: 1'b1, memtoreg: 1'b0, memread: 1'b0,
                    memwrite: 1'b1, regwrite: 1'b0, branch: 1'b0, jump: 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BEQ: begin
        dec     = '{aluop: 2'b01, alusrc: 1'b0, memtoreg: 1'b0, memread: 1'b0,
                    memwrite: 1'b0, regwrite: 1'b0, branch: 1'b1, jump: 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec     = '{aluop: 2'b00, alusrc: 1'b0, memtoreg: 1'b0, memread: 1'b0,
                    memwrite: 1'b0, regwrite: 1'b1, branch: 1'b0, jump: 1'b1};
      end
      default: dec = '0;
    endcase
    if (noop_i) begin
      dec = '0;
    end
  end

  // Load-use hazard; a squashed or bubble ID instruction never stalls.
  always_comb begin
    stall_o = ex_q.memread && (ex_rd_q != '0) && !noop_i && !flush_i &&
              ((use_rs1 && (rs1_i == ex_rd_q)) || (use_rs2 && (rs2_i == ex_rd_q)));
    bubble      = noop_i | flush_i | stall_o;
    id_branch_o = dec.branch & ~stall_o & ~flush_i;
    id_jump_o   = dec.jump & ~stall_o & ~flush_i;
  end

  // Next ID/EX contents: decoded control or an all-zero bubble.
  always_comb begin
    ex_d    = '0;
    ex_rd_d = '0;
    if (!bubble) begin
      ex_d = '{aluop: dec.aluop, alusrc: dec.alusrc, memtoreg: dec.memtoreg,
               memread: dec.memread, memwrite: dec.memwrite, regwrite: dec.regwrite};
      ex_rd_d = dec.regwrite ? rd_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q           <= '0;
      ex_rd_q        <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      ex_q           <= ex_d;
      ex_rd_q        <= ex_rd_d;
      mem_memread_q  <= ex_q.memread;
      mem_memwrite_q <= ex_q.memwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_regwrite_q <= ex_q.regwrite;
      mem_rd_q       <= ex_rd_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
    end else if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign ex_aluop_o     = ex_q.aluop;
  assign ex_alusrc_o    = ex_q.alusrc;
  assign ex_memread_o   = ex_q.memread;
  assign ex_rd_o        = ex_rd_q;
  assign mem_memread_o  = mem_memread_q;
  assign mem_memwrite_o = mem_memwrite_q;
  assign mem_memtoreg_o = mem_memtoreg_q;
  assign mem_regwrite_o = mem_regwrite_q;
  assign mem_rd_o       = mem_rd_q;
  assign wb_memtoreg_o  = wb_memtoreg_q;
  assign wb_regwrite_o  = wb_regwrite_q;
  assign wb_rd_o        = wb_rd_q;
  assign bubble_cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Randomized bench for control_pipe against a table-driven delay-line model;
// a second instance with a 2-bit counter exercises saturation.
module tb_control_pipe;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [6:0] op_i;
  logic       noop_i, flush_i;
  logic [4:0] rs1_i, rs2_i, rd_i;

  logic        id_branch_o, id_jump_o, stall_o;
  logic [1:0]  ex_aluop_o;
  logic        ex_alusrc_o, ex_memread_o;
  logic [4:0]  ex_rd_o;
  logic        mem_memread_o, mem_memwrite_o, mem_memtoreg_o, mem_regwrite_o;
  logic [4:0]  mem_rd_o;
  logic        wb_memtoreg_o, wb_regwrite_o;
  logic [4:0]  wb_rd_o;
  logic [15:0] bubble_cnt_o;

  logic        s_branch, s_jump, s_stall;
  logic [1:0]  s_ex_aluop;
  logic        s_ex_alusrc, s_ex_memread;
  logic [4:0]  s_ex_rd;
  logic        s_mem_memread, s_mem_memwrite, s_mem_memtoreg, s_mem_regwrite;
  logic [4:0]  s_mem_rd;
  logic        s_wb_memtoreg, s_wb_regwrite;
  logic [4:0]  s_wb_rd;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  control_pipe u_dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .noop_i(noop_i), .flush_i(flush_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .id_branch_o(id_branch_o), .id_jump_o(id_jump_o), .stall_o(stall_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o), .ex_memread_o(ex_memread_o),
    .ex_rd_o(ex_rd_o), .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
    .mem_memtoreg_o(mem_memtoreg_o), .mem_regwrite_o(mem_regwrite_o), .mem_rd_o(mem_rd_o),
    .wb_memtoreg_o(wb_memtoreg_o), .wb_regwrite_o(wb_regwrite_o), .wb_rd_o(wb_rd_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  control_pipe #(.ADDR_W(5), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .noop_i(noop_i), .flush_i(flush_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .id_branch_o(s_branch), .id_jump_o(s_jump), .stall_o(s_stall),
    .ex_aluop_o(s_ex_aluop), .ex_alusrc_o(s_ex_alusrc), .ex_memread_o(s_ex_memread),
    .ex_rd_o(s_ex_rd), .mem_memread_o(s_mem_memread), .mem_memwrite_o(s_mem_memwrite),
    .mem_memtoreg_o(s_mem_memtoreg), .mem_regwrite_o(s_mem_regwrite), .mem_rd_o(s_mem_rd),
    .wb_memtoreg_o(s_wb_memtoreg), .wb_regwrite_o(s_wb_regwrite), .wb_rd_o(s_wb_rd),
    .bubble_cnt_o(s_cnt)
  );

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [4:0] rd;
  } rec_t;

  rec_t m_ex, m_mem, m_wb;
  int   m_cnt;
  int   total = 0;
  int   bad   = 0;
  logic last_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ALUOp[8:7], ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite, Branch, Jump}
  function automatic logic [8:0] ref_dec(input logic [6:0] op);
    case (op)
      OP_R:     return 9'b10_0_0_0_0_1_0_0;
      OP_IALU:  return 9'b11_1_0_0_0_1_0_0;
      OP_LOAD:  return 9'b00_1_1_1_0_1_0_0;
      OP_STORE: return 9'b00_1_0_0_1_0_0_0;
      OP_BEQ:   return 9'b01_0_0_0_0_0_1_0;
      OP_JAL:   return 9'b00_0_0_0_0_1_0_1;
      default:  return 9'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BEQ};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BEQ};
  endfunction

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_regs();
    chk("ex", 32'({ex_aluop_o, ex_alusrc_o, ex_memread_o, ex_rd_o}),
        32'({m_ex.aluop, m_ex.alusrc, m_ex.memread, m_ex.rd}));
    chk("mem", 32'({mem_memread_o, mem_memwrite_o, mem_memtoreg_o, mem_regwrite_o, mem_rd_o}),
        32'({m_mem.memread, m_mem.memwrite, m_mem.memtoreg, m_mem.regwrite, m_mem.rd}));
    chk("wb", 32'({wb_memtoreg_o, wb_regwrite_o, wb_rd_o}),
        32'({m_wb.memtoreg, m_wb.regwrite, m_wb.rd}));
    chk("cnt", 32'(bubble_cnt_o), 32'(sat(m_cnt, 16)));
    chk("cnt_sat", 32'(s_cnt), 32'(sat(m_cnt, 2)));
  endtask

  // One ID cycle: drive at negedge, check decode, clock, check pipeline.
  task automatic step(input logic [6:0] a_op, input logic a_noop, input logic a_flush,
                      input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_rd);
    logic [8:0] d;
    logic       haz, bub;
    rec_t       nxt;
    op_i = a_op; noop_i = a_noop; flush_i = a_flush;
    rs1_i = a_rs1; rs2_i = a_rs2; rd_i = a_rd;
    #1;
    d   = a_noop ? 9'b0 : ref_dec(a_op);
    haz = m_ex.memread && (m_ex.rd != 5'd0) && !a_noop && !a_flush &&
          ((uses_rs1(a_op) && a_rs1 == m_ex.rd) || (uses_rs2(a_op) && a_rs2 == m_ex.rd));
    last_stall = stall_o;
    chk("stall", 32'(stall_o), 32'(haz));
    chk("branch", 32'(id_branch_o), 32'(d[1] && !haz && !a_flush));
    chk("jump", 32'(id_jump_o), 32'(d[0] && !haz && !a_flush));
    bub = a_noop || a_flush || haz;
    nxt = '0;
    if (!bub) begin
      nxt = '{aluop: d[8:7], alusrc: d[6], memtoreg: d[5], memread: d[4],
              memwrite: d[3], regwrite: d[2], rd: (d[2] ? a_rd : 5'd0)};
    end
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = nxt;
    if (bub) m_cnt++;
    @(negedge clk);
    check_regs();
  endtask

  // Asynchronous reset asserted away from both clock edges.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    check_regs();
    @(posedge clk);
    #1 check_regs();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 6))
      0: return OP_R;
      1: return OP_IALU;
      2: return OP_LOAD;
      3: return OP_STORE;
      4: return OP_BEQ;
      5: return OP_JAL;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    int exp_sat [5];
    exp_sat[0] = 1; exp_sat[1] = 2; exp_sat[2] = 3; exp_sat[3] = 3; exp_sat[4] = 3;
    rst_i = 1'b0; op_i = '0; noop_i = 1'b0; flush_i = 1'b0;
    rs1_i = '0; rs2_i = '0; rd_i = '0;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; last_stall = 1'b0;
    do_reset();

    // R-type flows through to WB three cycles after ID
    step(OP_R, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    chk("r_ex_aluop", 32'(ex_aluop_o), 32'd2);
    chk("r_ex_rd", 32'(ex_rd_o), 32'd3);
    step(7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("r_wb", 32'({wb_regwrite_o, wb_rd_o}), 32'({1'b1, 5'd3}));

    // load-use on beq: one stall, then beq enters EX
    do_reset();
    step(OP_LOAD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
    step(OP_BEQ, 1'b0, 1'b0, 5'd5, 5'd1, 5'd9);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_cnt", 32'(bubble_cnt_o), 32'd1);
    step(OP_BEQ, 1'b0, 1'b0, 5'd5, 5'd1, 5'd9);
    chk("lu_release", 32'(last_stall), 32'd0);
    chk("lu_beq_ex", 32'(ex_aluop_o), 32'd1);

    // x0 destination never stalls
    step(OP_LOAD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
    step(OP_R, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4);
    chk("x0_stall", 32'(last_stall), 32'd0);

    // I-ALU ignores rs2
    step(OP_LOAD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd6);
    step(OP_IALU, 1'b0, 1'b0, 5'd1, 5'd6, 5'd7);
    chk("ialu_stall", 32'(last_stall), 32'd0);

    // flush coinciding with a load-use hazard: exactly one bubble
    do_reset();
    step(OP_LOAD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
    step(OP_BEQ, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
    chk("fl_cnt", 32'(bubble_cnt_o), 32'd1);
    chk("fl_ex", 32'({ex_aluop_o, ex_memread_o, ex_rd_o}), 32'd0);

    // 2-bit counter saturates, then async reset clears everything
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      chk("sat_seq", 32'(s_cnt), 32'(exp_sat[i]));
    end
    step(OP_LOAD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd8);
    do_reset();

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(rand_op(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
